// File: rtl/program_loader_if.sv
// Purpose : loader bus bundle grouping the start request, the byte-stream handshake, the RAM write port and the status flags.
// Latency : none; wires only.
// Backpressure: the stream source holds in_valid/in_data until it sees in_ready.
// Ports (slave = loader side):
//   in : start, in_valid, in_data
//   out: in_ready, ram_addr, ram_data, ram_we, cpu_clr, done, err
// The master modport is the mirror image, for the stream source / RAM / CPU side.
interface program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_we;
    logic              cpu_clr;
    logic              done;
    logic              err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, ram_addr, ram_data, ram_we, cpu_clr, done, err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, ram_addr, ram_data, ram_we, cpu_clr, done, err
    );
endinterface

// File: rtl/program_loader.sv
// Purpose : loads a length-prefixed byte image into RAM while holding the CPU in clear, then releases it.
// Latency : each accepted data byte appears on the RAM write port one cycle later (registered).
// Backpressure: in_ready is high only in HDR/LOAD/CHK; in_valid stalls of any length freeze all state.
// Ports:
//   clk    - single clock, rising edge
//   clr_n  - synchronous active-low reset
//   bus    - program_loader_if.slave (start, stream handshake, RAM write port, cpu_clr/done/err)
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing checksum byte that makes the
// 8-bit sum of all data bytes plus the checksum equal zero; a mismatch parks the loader in ERR.
module program_loader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int CLR_HOLD = 4
) (
    input  logic            clk,
    input  logic            clr_n,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        CHK  = 3'd3,
        HOLD = 3'd4,
        RUN  = 3'd5,
        ERR  = 3'd6
    } state_t;

    // Wide enough to hold CLR_HOLD itself (and 1 when CLR_HOLD is 0).
    localparam int                HOLD_W    = $clog2(CLR_HOLD + 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLR_HOLD);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    // Index of the final data byte: header count minus one, so a header of 0 wraps to the full RAM.
    logic [ADDR_W-1:0] last_q,  last_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q,   sum_d;
    logic [7:0]        chk_total;
`endif

    logic in_ready;
    logic accept;

    assign in_ready = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
    assign accept   = bus.in_valid && in_ready;

`ifdef LOADER_CHECKSUM_EN
    assign chk_total = sum_q + 8'(bus.in_data);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = HDR;
            end
            HDR: begin
                if (accept) begin
                    last_d  = bus.in_data[ADDR_W-1:0] - ADDR_W'(1);
                    ptr_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    data_d = bus.in_data;
                    ptr_d  = ptr_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + 8'(bus.in_data);
`endif
                    if (ptr_q == last_q) begin
                        // hold_q = 0 here: the cycle carrying the final write is not counted.
                        hold_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = HOLD;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    // The final write is already behind us, so the HOLD entry cycle counts as hold cycle 1.
                    if (chk_total == 8'd0) begin
                        hold_d  = HOLD_W'(1);
                        state_d = HOLD;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
`endif
            HOLD: begin
                if (hold_q >= HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = RUN;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (bus.start) state_d = HDR;
            end
            ERR: begin
                if (bus.start) state_d = HDR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also drops any write registered from the byte accepted on the previous edge.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.ram_we   = we_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_data = data_q;
    assign bus.cpu_clr  = (state_q != RUN);
    assign bus.done     = (state_q == RUN);
    assign bus.err      = (state_q == ERR);

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: ADDR_W, 4, RAM address width; image holds at most 2^ADDR_W bytes.
REQ-002 Parameter: DATA_W, 8, RAM word and stream byte width.
REQ-003 Parameter: CLR_HOLD, 4, clk cycles that cpu_clr stays asserted after the last RAM write.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: clr_n  input  1  reset, synchronous, active-low.
REQ-006 Port: start  input  1  one-cycle request to begin loading an image.
REQ-007 Port: in_valid  input  1  stream byte present on in_data.
REQ-008 Port: in_data  input  DATA_W  stream byte.
REQ-009 Port: in_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: ram_addr  output  ADDR_W  RAM write address.
REQ-011 Port: ram_data  output  DATA_W  RAM write data.
REQ-012 Port: ram_we  output  1  RAM write strobe, one cycle per word.
REQ-013 Port: cpu_clr  output  1  holds the computer in clear, active-high.
REQ-014 Port: done  output  1  image loaded, computer released.
REQ-015 Port: err  output  1  load failed.

Function
REQ-016 States SHALL be IDLE, HDR, LOAD, CHK, HOLD, RUN, ERR.
REQ-017 A byte SHALL transfer only on a rising edge with in_valid=1 and in_ready=1; in_ready=1 exactly in HDR, LOAD, CHK.
REQ-018 IDLE: start=1 -> HDR; otherwise stay.
REQ-019 HDR: accepted byte sets count N = in_data[ADDR_W-1:0], N=0 meaning 2^ADDR_W; upper header bits ignored; -> LOAD with address pointer 0.
REQ-020 LOAD: each accepted byte SHALL drive ram_addr=pointer, ram_data=byte, ram_we=1 on the following cycle (latency 1, registered); pointer increments modulo 2^ADDR_W.
REQ-021 After the Nth data byte: -> CHK if CHECKSUM_EN defined, else -> HOLD.
REQ-022 HOLD: count CLR_HOLD cycles starting the cycle after the last ram_we, then -> RUN.
REQ-023 cpu_clr SHALL be 1 in every state except RUN; done=1 only in RUN; err=1 only in ERR.
REQ-024 RUN: start=1 -> HDR (reload); cpu_clr rises on the next edge.
REQ-025 ERR: start=1 -> HDR with err cleared; otherwise stay; no RAM writes.
REQ-026 start SHALL be ignored in HDR, LOAD, CHK, HOLD.
REQ-027 Stalls (in_valid=0) of any length SHALL not change state, pointer or checksum.
REQ-028 ram_we SHALL be 0 in all cycles other than those in REQ-020; addresses never written in a load retain their contents.

Reset
REQ-029 clr_n=0 at a rising edge SHALL force IDLE, pointer=0, checksum=0, hold counter=0, ram_we=0, ram_addr=0, ram_data=0, in_ready=0, done=0, err=0, cpu_clr=1.
REQ-030 Reset mid-load SHALL abort with no further ram_we, including a write pending from the previous cycle's accepted byte.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN: when defined, an 8-bit running sum (mod 256) of data bytes is kept; CHK accepts one byte, and if sum+byte == 0 mod 256 -> HOLD, else -> ERR.
REQ-032 Without LOADER_CHECKSUM_EN: no CHK byte is consumed, no sum register exists, err stays 0 permanently.

Verification
REQ-033 Reset, start, stream 0x0C then 20 2F E0 14 E4 20 E3 2D E4 20 E3 2D -> 12 ram_we pulses addr 0..B with those data, cpu_clr falls 4 cycles after last write, done=1.
REQ-034 Header 0x00 followed by 16 bytes 00..0F -> writes to addr 0..F, pointer wraps to 0, done=1.
REQ-035 in_valid toggled 1/0 every cycle during the load of REQ-033 -> identical RAM writes, only timing stretched.
REQ-036 LOADER_CHECKSUM_EN: header 0x02, data 10 20, checksum D0 -> done=1; checksum D1 -> err=1, cpu_clr stays 1; start then clears err.
REQ-037 clr_n=0 for one cycle after the 5th data byte -> no further ram_we, cpu_clr=1, state IDLE, later start reloads cleanly.
REQ-038 start asserted in RUN -> cpu_clr=1 next cycle, in_ready=1, new header accepted.
